// File: rtl/most_ones_pkg.sv
// Shared constants and width helpers for the most_ones voter family.
package most_ones_pkg;

    localparam int unsigned TIE_ZERO  = 0;
    localparam int unsigned TIE_ONE_C = 1;

    // Ceiling log2, with clog2(0) = clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Width needed to hold a popcount of w bits (0..w).
    function automatic int unsigned CW(input int unsigned w);
        return clog2(w + 1);
    endfunction

    // Width needed to hold a window count of d decisions (0..d).
    function automatic int unsigned WCW(input int unsigned d);
        return clog2(d + 1);
    endfunction

endpackage

// File: rtl/most_ones_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module most_ones_popcount
    import most_ones_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0]     x,
    output logic [CW(WIDTH)-1:0] count
);

    localparam int unsigned CWL = CW(WIDTH);

    // Sum of all input bits; the result width can hold WIDTH without overflow.
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            count = count + CWL'(x[i]);
        end
    end

endmodule

// File: rtl/most_ones_filter.sv
// Two-stage majority voter with a sliding-window temporal majority filter.
// Optional feature: define MOST_ONES_COUNT_OUT_EN to expose the per-sample
// popcount on port ones.
module most_ones_filter
    import most_ones_pkg::*;
#(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned DEPTH   = 5,
    parameter int unsigned TIE_ONE = TIE_ZERO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    output logic             out_valid,
    output logic             y,
    output logic             y_filt,
    output logic             warm
`ifdef MOST_ONES_COUNT_OUT_EN
    ,
    output logic [CW(WIDTH)-1:0] ones
`endif
);

    localparam int unsigned CWL  = CW(WIDTH);
    localparam int unsigned WCWL = WCW(DEPTH);
    localparam bit          TIE  = (TIE_ONE != TIE_ZERO);

    logic [CWL-1:0]   cnt1;
    logic             maj1_d;
    logic             maj1_q;
    logic             v1_q;
`ifdef MOST_ONES_COUNT_OUT_EN
    logic [CWL-1:0]   cnt1_q;
    logic [CWL-1:0]   ones_q;
`endif

    logic [DEPTH-1:0] hist_q, hist_d;
    logic [WCWL-1:0]  wcnt_q, wcnt_d;
    logic [WCWL-1:0]  fill_q, fill_d;
    logic             yfilt_d;
    logic             out_valid_q, y_q, y_filt_q, warm_q;

    most_ones_popcount #(.WIDTH(WIDTH)) u_popcount (
        .x     (x),
        .count (cnt1)
    );

    // Instant majority of the incoming sample, ties resolved by TIE_ONE.
    always_comb begin
        maj1_d = (32'd2 * 32'(cnt1) > WIDTH) | (TIE & (32'd2 * 32'(cnt1) == WIDTH));
    end

    // Stage 1: capture the instant decision of each valid sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            maj1_q <= 1'b0;
`ifdef MOST_ONES_COUNT_OUT_EN
            cnt1_q <= '0;
`endif
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                maj1_q <= maj1_d;
`ifdef MOST_ONES_COUNT_OUT_EN
                cnt1_q <= cnt1;
`endif
            end
        end
    end

    // Window next state; the shift form also covers DEPTH=1 (hist becomes maj1).
    always_comb begin
        hist_d  = (hist_q << 1) | DEPTH'(maj1_q);
        wcnt_d  = wcnt_q + WCWL'(maj1_q) - WCWL'(hist_q[DEPTH-1]);
        fill_d  = (fill_q == WCWL'(DEPTH)) ? fill_q : fill_q + WCWL'(1);
        yfilt_d = (32'd2 * 32'(wcnt_d) > DEPTH) | (TIE & (32'd2 * 32'(wcnt_d) == DEPTH));
    end

    // Stage 2: advance the window only on valid samples and register outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= 1'b0;
            y_filt_q    <= 1'b0;
            warm_q      <= 1'b0;
            hist_q      <= '0;
            wcnt_q      <= '0;
            fill_q      <= '0;
`ifdef MOST_ONES_COUNT_OUT_EN
            ones_q      <= '0;
`endif
        end else begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                hist_q   <= hist_d;
                wcnt_q   <= wcnt_d;
                fill_q   <= fill_d;
                y_q      <= maj1_q;
                y_filt_q <= yfilt_d;
                warm_q   <= (fill_d == WCWL'(DEPTH));
`ifdef MOST_ONES_COUNT_OUT_EN
                ones_q   <= cnt1_q;
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign y_filt    = y_filt_q;
    assign warm      = warm_q;
`ifdef MOST_ONES_COUNT_OUT_EN
    assign ones      = ones_q;
`endif

endmodule
